// File: rtl/mark_pkg.sv
// mark_pkg: shared sizes, FSM states and mark unpacking for the Golomb-ruler mark counters
package mark_pkg;
  localparam int NUMPOSITIONS = 5;
  localparam int MAXVALUE = 49;
  localparam int PVW = 9;
  localparam int PNW = 4;
  localparam int FIRST_VARIABLE = 1;
  localparam int MW = (NUMPOSITIONS + 1) * PVW;
  typedef enum logic [1:0] {INIT, IDLE, SEARCH} state_t;
  function automatic logic [PVW-1:0] get_mark(input logic [MW-1:0] marks, input int j);
    return marks[(NUMPOSITIONS - j) * PVW +: PVW];
  endfunction
endpackage

// File: rtl/mark_counter_head.sv
// mark_counter_head: mark 0, permanently at position 0 and always ready
module mark_counter_head
  import mark_pkg::*;
(
  input  logic           clock,
  input  logic           RESET,
  output logic           ready,
  output logic [PVW-1:0] val,
  output logic [PVW-1:0] nextStartValue
);
  logic unused_in;
  assign unused_in = clock ^ RESET;
  assign ready = 1'b1;
  assign val = '0;
  assign nextStartValue = PVW'(1);
endmodule

// File: rtl/mark_counter_leaf.sv
// mark_counter_leaf: final mark; flags success when a complete ruler is found. MARK_LIMIT_PRUNE_EN enables limit pruning.
module mark_counter_leaf
  import mark_pkg::*;
#(
  parameter int POSITION = NUMPOSITIONS
) (
  input  logic                clock,
  input  logic                RESET,
  output logic                ready,
  input  logic                globalready,
  input  logic [PVW-1:0]      startvalue,
  input  logic [PVW-1:0]      limit,
  input  logic [PNW-1:0]      enabled,
  output logic [PVW-1:0]      val,
  output logic [PNW-1:0]      nextEnabled,
  input  logic [MAXVALUE-1:0] distances,
  input  logic [MW-1:0]       marks_in,
  output logic                success
);
  state_t state_q, state_d;
  logic [PVW-1:0] val_q, val_d, cand_q, cand_d;
  logic [PNW-1:0] ne_q, ne_d;
  logic [MAXVALUE-1:0] hash_c;
  logic succ_q, succ_d, gr_q, too_big, trigger;
  mark_dist_hash #(.POSITION(POSITION)) u_hash (
    .cand    (state_q == SEARCH ? cand_q : startvalue),
    .marks_in(marks_in),
    .hash    (hash_c)
  );
`ifdef MARK_LIMIT_PRUNE_EN
  assign too_big = cand_q > limit || cand_q > PVW'(MAXVALUE);
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign too_big = cand_q > PVW'(MAXVALUE);
`endif
  assign trigger = !gr_q && globalready && enabled == PNW'(POSITION);
  assign ready = state_q == IDLE;
  assign val = val_q;
  assign nextEnabled = ne_q;
  assign success = succ_q;
  // next state: start on a rising globalready, then test one candidate per clock
  always_comb begin
    state_d = state_q;
    val_d = val_q;
    cand_d = cand_q;
    ne_d = ne_q;
    succ_d = succ_q;
    if (state_q == INIT) state_d = IDLE;
    else if (state_q == IDLE && POSITION < FIRST_VARIABLE) val_d = startvalue;
    else if (state_q == IDLE && trigger) begin
      state_d = SEARCH;
      cand_d = val_q == '0 ? startvalue : val_q + PVW'(1);
      succ_d = 1'b0;
    end else if (state_q == SEARCH && too_big) begin
      state_d = IDLE;
      val_d = '0;
      ne_d = PNW'(POSITION - 1);
    end else if (state_q == SEARCH && (hash_c & distances) == '0) begin
      state_d = IDLE;
      val_d = cand_q;
      ne_d = PNW'(NUMPOSITIONS);
      succ_d = 1'b1;
    end else if (state_q == SEARCH) cand_d = cand_q + PVW'(1);
  end
  // state registers with asynchronous reset
  always_ff @(posedge clock or posedge RESET)
    if (RESET) begin
      state_q <= INIT;
      val_q <= '0;
      cand_q <= '0;
      ne_q <= PNW'(POSITION);
      succ_q <= 1'b0;
      gr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      cand_q <= cand_d;
      ne_q <= ne_d;
      succ_q <= succ_d;
      gr_q <= globalready;
    end
endmodule

// File: rtl/mark_dist_hash.sv
// mark_dist_hash: distance vector from a candidate position to every earlier mark (distance 1 in the MSB)
module mark_dist_hash
  import mark_pkg::*;
#(
  parameter int POSITION = 1
) (
  input  logic [PVW-1:0]      cand,
  input  logic [MW-1:0]       marks_in,
  output logic [MAXVALUE-1:0] hash
);
  localparam logic [MAXVALUE-1:0] D1 = {1'b1, {(MAXVALUE-1){1'b0}}};
  // the candidate is checked against each mark before subtracting, so no distance wraps
  always_comb begin
    hash = '0;
    for (int j = 0; j < POSITION; j++)
      if (cand > get_mark(marks_in, j) && cand - get_mark(marks_in, j) <= PVW'(MAXVALUE))
        hash = hash | (D1 >> (cand - get_mark(marks_in, j) - PVW'(1)));
  end
endmodule

// File: rtl/mark_counter.sv
// mark_counter: middle mark of the ruler search; finds the next position with unused distances. MARK_LIMIT_PRUNE_EN enables limit pruning.
module mark_counter
  import mark_pkg::*;
#(
  parameter int POSITION = 1
) (
  input  logic                clock,
  input  logic                RESET,
  output logic                ready,
  input  logic                globalready,
  input  logic [PVW-1:0]      startvalue,
  input  logic [PVW-1:0]      limit,
  input  logic [PNW-1:0]      enabled,
  output logic [PVW-1:0]      val,
  output logic [PNW-1:0]      nextEnabled,
  output logic [PVW-1:0]      nextStartValue,
  input  logic [MAXVALUE-1:0] distances,
  output logic [MAXVALUE-1:0] pdHash,
  input  logic [MW-1:0]       marks_in
);
  state_t state_q, state_d;
  logic [PVW-1:0] val_q, val_d, cand_q, cand_d, nsv_q, nsv_d;
  logic [PNW-1:0] ne_q, ne_d;
  logic [MAXVALUE-1:0] hash_q, hash_d, hash_c;
  logic gr_q, too_big, trigger;
  mark_dist_hash #(.POSITION(POSITION)) u_hash (
    .cand    (state_q == SEARCH ? cand_q : startvalue),
    .marks_in(marks_in),
    .hash    (hash_c)
  );
`ifdef MARK_LIMIT_PRUNE_EN
  assign too_big = cand_q > limit || cand_q > PVW'(MAXVALUE);
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign too_big = cand_q > PVW'(MAXVALUE);
`endif
  assign trigger = !gr_q && globalready && enabled == PNW'(POSITION);
  assign ready = state_q == IDLE;
  assign val = val_q;
  assign nextEnabled = ne_q;
  assign nextStartValue = nsv_q;
  assign pdHash = hash_q;
  // next state: own distances are masked out of the global set before the collision test
  always_comb begin
    state_d = state_q;
    val_d = val_q;
    cand_d = cand_q;
    nsv_d = nsv_q;
    hash_d = hash_q;
    ne_d = ne_q;
    if (state_q == INIT) state_d = IDLE;
    else if (state_q == IDLE && POSITION < FIRST_VARIABLE) begin
      val_d = startvalue;
      hash_d = hash_c;
      nsv_d = startvalue + PVW'(1);
    end else if (state_q == IDLE && trigger) begin
      state_d = SEARCH;
      cand_d = val_q == '0 ? startvalue : val_q + PVW'(1);
    end else if (state_q == SEARCH && too_big) begin
      state_d = IDLE;
      val_d = '0;
      hash_d = '0;
      ne_d = PNW'(POSITION - 1);
    end else if (state_q == SEARCH && (hash_c & distances & ~hash_q) == '0) begin
      state_d = IDLE;
      val_d = cand_q;
      hash_d = hash_c;
      nsv_d = cand_q + PVW'(1);
      ne_d = PNW'(POSITION + 1);
    end else if (state_q == SEARCH) cand_d = cand_q + PVW'(1);
  end
  // state registers with asynchronous reset
  always_ff @(posedge clock or posedge RESET)
    if (RESET) begin
      state_q <= INIT;
      val_q <= '0;
      cand_q <= '0;
      nsv_q <= PVW'(1);
      hash_q <= '0;
      ne_q <= PNW'(POSITION);
      gr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      cand_q <= cand_d;
      nsv_q <= nsv_d;
      hash_q <= hash_d;
      ne_q <= ne_d;
      gr_q <= globalready;
    end
endmodule

// File: tb/tb_mark_counter.sv
// tb_mark_counter: directed scoreboard bench for the head, two middle marks and the leaf
module tb_mark_counter;
  import mark_pkg::*;
  typedef struct {
    logic [PVW-1:0]      val;
    logic [MAXVALUE-1:0] hash;
    logic [PNW-1:0]      ne;
    logic [PVW-1:0]      aux;
    int                  cyc;
  } exp_t;
  logic clock = 1'b0, RESET = 1'b0, globalready = 1'b0;
  logic [PVW-1:0] startvalue = '0, limit = '0;
  logic [PNW-1:0] enabled = '0;
  logic [MAXVALUE-1:0] distances = '0;
  logic [MW-1:0] marks_in = '0;
  logic rh, r1, r2, rl, succ;
  logic [PVW-1:0] vh, nh, v1, n1, v2, n2, vl;
  logic [PNW-1:0] e1, e2, el;
  logic [MAXVALUE-1:0] p1, p2;
  int who = 1;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];
  logic s_ready;
  logic [PVW-1:0] s_val, s_aux;
  logic [PNW-1:0] s_ne;
  logic [MAXVALUE-1:0] s_hash;

  always #5 clock = ~clock;

  mark_counter_head u_head (.clock(clock), .RESET(RESET), .ready(rh), .val(vh), .nextStartValue(nh));
  mark_counter #(.POSITION(1)) u_m1 (
    .clock(clock), .RESET(RESET), .ready(r1), .globalready(globalready), .startvalue(startvalue),
    .limit(limit), .enabled(enabled), .val(v1), .nextEnabled(e1), .nextStartValue(n1),
    .distances(distances), .pdHash(p1), .marks_in(marks_in));
  mark_counter #(.POSITION(2)) u_m2 (
    .clock(clock), .RESET(RESET), .ready(r2), .globalready(globalready), .startvalue(startvalue),
    .limit(limit), .enabled(enabled), .val(v2), .nextEnabled(e2), .nextStartValue(n2),
    .distances(distances), .pdHash(p2), .marks_in(marks_in));
  mark_counter_leaf #(.POSITION(5)) u_leaf (
    .clock(clock), .RESET(RESET), .ready(rl), .globalready(globalready), .startvalue(startvalue),
    .limit(limit), .enabled(enabled), .val(vl), .nextEnabled(el), .distances(distances),
    .marks_in(marks_in), .success(succ));

  assign s_ready = who == 1 ? r1 : who == 2 ? r2 : rl;
  assign s_val = who == 1 ? v1 : who == 2 ? v2 : vl;
  assign s_ne = who == 1 ? e1 : who == 2 ? e2 : el;
  assign s_aux = who == 1 ? n1 : who == 2 ? n2 : PVW'(succ);
  assign s_hash = who == 1 ? p1 : p2;

  function automatic logic [MAXVALUE-1:0] dbit(input int d);
    logic [MAXVALUE-1:0] one;
    one = {1'b1, {(MAXVALUE-1){1'b0}}};
    return one >> (d - 1);
  endfunction

  function automatic exp_t mk(input int v, input logic [MAXVALUE-1:0] h, input int ne, input int aux, input int cyc);
    exp_t e;
    e.val = PVW'(v);
    e.hash = h;
    e.ne = PNW'(ne);
    e.aux = PVW'(aux);
    e.cyc = cyc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    RESET = 1'b1;
    globalready = 1'b0;
    enabled = '0;
    #1;
    chk({tag, "_val1"}, 64'(v1), 64'(0));
    chk({tag, "_val2"}, 64'(v2), 64'(0));
    chk({tag, "_hash2"}, 64'(p2), 64'(0));
    chk({tag, "_ne2"}, 64'(e2), 64'(2));
    chk({tag, "_nsv2"}, 64'(n2), 64'(1));
    chk({tag, "_leaf_ne"}, 64'(el), 64'(5));
    chk({tag, "_leaf_succ"}, 64'(succ), 64'(0));
    @(negedge clock);
    RESET = 1'b0;
    #1;
    chk({tag, "_init_ready"}, 64'({r1, r2, rl}), 64'(0));
    @(negedge clock);
    chk({tag, "_idle_ready"}, 64'({r1, r2, rl}), 64'(3'b111));
    chk({tag, "_head"}, 64'({rh, vh, nh}), 64'({1'b1, 9'd0, 9'd1}));
  endtask

  task automatic search(input string tag, input int w, input exp_t e);
    int cyc;
    bit done;
    exp_t x;
    cyc = 0;
    done = 1'b0;
    sb.push_back(e);
    @(negedge clock);
    globalready = 1'b0;
    enabled = PNW'(w);
    who = w;
    @(negedge clock);
    globalready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (s_ready) done = 1'b1;
      else cyc++;
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    x = sb.pop_front();
    chk({tag, "_cycles"}, 64'(cyc), 64'(x.cyc));
    chk({tag, "_val"}, 64'(s_val), 64'(x.val));
    chk({tag, "_ne"}, 64'(s_ne), 64'(x.ne));
    chk({tag, "_aux"}, 64'(s_aux), 64'(x.aux));
    if (w != 5) chk({tag, "_hash"}, 64'(s_hash), 64'(x.hash));
  endtask

  initial begin
    marks_in = {9'd0, 9'd1, 9'd4, 9'd10, 9'd12, 9'd0};
    do_reset("rst1");
    startvalue = 9'd1;
    limit = 9'd30;
    distances = '0;
    search("m1_first", 1, mk(1, dbit(1), 2, 2, 1));
    startvalue = 9'd2;
    distances = dbit(1);
    search("m2_collide", 2, mk(3, dbit(2) | dbit(3), 3, 4, 2));
    distances = dbit(1) | dbit(2) | dbit(3);
    search("m2_resume", 2, mk(4, dbit(3) | dbit(4), 3, 5, 1));
    @(negedge clock);
    globalready = 1'b0;
    enabled = 4'd4;
    @(negedge clock);
    globalready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("other_enabled_ready", 64'({r1, r2, rl}), 64'(3'b111));
    end
    chk("other_enabled_val2", 64'(v2), 64'(4));
    do_reset("rst2");
    startvalue = 9'd2;
    limit = 9'd2;
    distances = dbit(1);
`ifdef MARK_LIMIT_PRUNE_EN
    search("m2_limit", 2, mk(0, '0, 1, 1, 2));
`else
    search("m2_limit", 2, mk(3, dbit(2) | dbit(3), 3, 4, 2));
`endif
    startvalue = 9'd13;
    limit = 9'd49;
    distances = dbit(1) | dbit(2) | dbit(3) | dbit(4) | dbit(6) | dbit(8) | dbit(9) | dbit(10) | dbit(11) | dbit(12);
    search("leaf_found", 5, mk(17, '0, 5, 1, 5));
    startvalue = 9'd50;
    limit = 9'd60;
    distances = '0;
    search("m1_over_max", 1, mk(0, '0, 0, 1, 1));
    startvalue = 9'd49;
    search("m1_at_max", 1, mk(49, dbit(49), 2, 50, 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
